id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL provide clk, input, 1 bit: the pipeline clock; all state updates on its rising edge.
REQ-002 The block SHALL provide rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL provide id_valid, input, 1 bit: the decode stage holds a real instruction.
REQ-004 The block SHALL provide id_reg_write, id_is_signed, id_reg_dst, id_jump, id_branch, id_mem_to_reg, id_mem_write and id_mem_read, inputs, 1 bit each: decoded control flags.
REQ-005 The block SHALL provide id_alu_sel, input, 2 bits: ALU operand-B select.
REQ-006 The block SHALL provide id_alu_code, input, 6 bits: ALU operation code.
REQ-007 The block SHALL provide id_rs, id_rt and id_rd, inputs, 5 bits each: register specifiers.
REQ-008 The block SHALL provide id_rs_data, id_rt_data, id_imm and id_pc4, inputs, 32 bits each: operands, sign-extended immediate and PC+4.
REQ-009 The block SHALL provide ex_flush, input, 1 bit: a taken branch/jump resolved in EX; kills the instruction in ID.
REQ-010 The block SHALL provide outputs ex_<name> for every id_<name> of REQ-003..REQ-008, same widths, registered; ex_valid is the registered id_valid.
REQ-011 The block SHALL provide stall, output, 1 bit, combinational: hold the PC and the IF/ID register this cycle.
REQ-012 The block SHALL provide bubble_cnt, output, 32 bits, only when ID_EX_BUBBLE_CNT_EN is defined.

Function
REQ-013 The block SHALL compute hazard = ex_valid & ex_mem_read & (ex_rt!=0) & id_valid & ((ex_rt==id_rs) | ((ex_rt==id_rt) & (id_reg_dst|id_mem_write|id_branch))).
REQ-014 The block SHALL drive stall = hazard & ~ex_flush.
REQ-015 The block SHALL resolve each rising edge with priority ex_flush > hazard > capture: flush or hazard loads a bubble; otherwise it loads all id_* into ex_*.
REQ-016 A bubble SHALL load ex_valid=0 and zero on every other ex_* output (control, alu_sel, alu_code, specifiers, data).
REQ-017 id_valid=0 without flush or hazard SHALL load the same all-zero state as a bubble.
REQ-018 ID-to-EX latency SHALL be exactly one clock, with no combinational path from id_* to ex_*.
REQ-019 A load-use stall SHALL last exactly one cycle: the bubble clears ex_mem_read; back-to-back loads each cost one bubble.
REQ-020 ex_rt==0 SHALL never cause a stall.
REQ-021 Simultaneous ex_flush and hazard SHALL insert a bubble with stall=0.

Reset
REQ-022 rst high SHALL clear all ex_* outputs and bubble_cnt to 0 immediately, independent of clk; stall is then 0 because ex_valid=0.
REQ-023 After rst deasserts, the first capture SHALL occur on the next rising edge, with no stall pending.

Configuration
REQ-024 With ID_EX_BUBBLE_CNT_EN defined, bubble_cnt SHALL increment by 1 on each edge loading a hazard bubble (not on flush or id_valid=0 loads) and wrap 0xFFFFFFFF->0.
REQ-025 With ID_EX_BUBBLE_CNT_EN undefined, the bubble_cnt port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-026 The bench SHALL cover: EX lw (ex_mem_read=1, ex_rt=5), ID add rs=5 -> stall=1 for one cycle; next edge ex_valid=0, ex_mem_read=0; following edge add captured, stall=0; bubble_cnt=1.
REQ-027 The bench SHALL cover: EX lw ex_rt=0, ID add rs=0 -> stall=0; add captured next edge with ex_valid=1.
REQ-028 The bench SHALL cover: EX lw ex_rt=5, ID addi rs=3, rt=5, reg_dst=0, mem_write=0, branch=0 -> stall=0; addi captured.
REQ-029 The bench SHALL cover: hazard plus ex_flush=1 in the same cycle -> stall=0; next edge ex_valid=0 and all ex_* zero; bubble_cnt unchanged.
REQ-030 The bench SHALL cover: rst pulsed between edges while ex_reg_write=1, ex_pc4=0x40 -> both read 0 before the next rising edge; bubble_cnt=0.
REQ-031 The bench SHALL cover: bubble_cnt preset to 0xFFFFFFFF via 2^32-1 hazards (or force), then one more hazard -> bubble_cnt=0x00000000.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline bus: decode-stage fields in, execute-stage fields and the
// load-use stall out. The master side drives decode; the slave side is the register.
interface id_ex_reg_if #(
    parameter int DATA_W = 32
);
    logic              id_valid;
    logic              id_reg_write;
    logic              id_is_signed;
    logic              id_reg_dst;
    logic              id_jump;
    logic              id_branch;
    logic              id_mem_to_reg;
    logic              id_mem_write;
    logic              id_mem_read;
    logic [1:0]        id_alu_sel;
    logic [5:0]        id_alu_code;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;
    logic              ex_flush;

    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_is_signed;
    logic              ex_reg_dst;
    logic              ex_jump;
    logic              ex_branch;
    logic              ex_mem_to_reg;
    logic              ex_mem_write;
    logic              ex_mem_read;
    logic [1:0]        ex_alu_sel;
    logic [5:0]        ex_alu_code;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic              stall;

    modport master (
        output id_valid, id_reg_write, id_is_signed, id_reg_dst, id_jump, id_branch,
               id_mem_to_reg, id_mem_write, id_mem_read, id_alu_sel, id_alu_code,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc4, ex_flush,
        input  ex_valid, ex_reg_write, ex_is_signed, ex_reg_dst, ex_jump, ex_branch,
               ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_alu_sel, ex_alu_code,
               ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc4, stall
    );

    modport slave (
        input  id_valid, id_reg_write, id_is_signed, id_reg_dst, id_jump, id_branch,
               id_mem_to_reg, id_mem_write, id_mem_read, id_alu_sel, id_alu_code,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc4, ex_flush,
        output ex_valid, ex_reg_write, ex_is_signed, ex_reg_dst, ex_jump, ex_branch,
               ex_mem_to_reg, ex_mem_write, ex_mem_read, ex_alu_sel, ex_alu_code,
               ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc4, stall
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Define ID_EX_BUBBLE_CNT_EN to add the bubble_cnt hazard-bubble counter port.
module id_ex_reg #(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_reg_if.slave  bus
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0] bubble_cnt
`endif
);
    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic                     is_signed;
        logic                     reg_dst;
        logic                     jump;
        logic                     branch;
        logic                     mem_to_reg;
        logic                     mem_write;
        logic                     mem_read;
        logic [1:0]               alu_sel;
        logic [5:0]               alu_code;
        logic [4:0]               rs;
        logic [4:0]               rt;
        logic [4:0]               rd;
        logic signed [DATA_W-1:0] rs_data;
        logic signed [DATA_W-1:0] rt_data;
        logic signed [DATA_W-1:0] imm;
        logic signed [DATA_W-1:0] pc4;
    } stage_t;

    stage_t id_p0;
    stage_t ex_p1;
    logic   rt_read_p0;
    logic   hazard_p0;
    logic   load_bubble_p0;

    // ---- stage p0: decode-side fields and hazard decision ----
    assign id_p0 = '{
        valid:      bus.id_valid,
        reg_write:  bus.id_reg_write,
        is_signed:  bus.id_is_signed,
        reg_dst:    bus.id_reg_dst,
        jump:       bus.id_jump,
        branch:     bus.id_branch,
        mem_to_reg: bus.id_mem_to_reg,
        mem_write:  bus.id_mem_write,
        mem_read:   bus.id_mem_read,
        alu_sel:    bus.id_alu_sel,
        alu_code:   bus.id_alu_code,
        rs:         bus.id_rs,
        rt:         bus.id_rt,
        rd:         bus.id_rd,
        rs_data:    bus.id_rs_data,
        rt_data:    bus.id_rt_data,
        imm:        bus.id_imm,
        pc4:        bus.id_pc4
    };

    // rt is a source only for R-type, store and branch forms
    assign rt_read_p0 = bus.id_reg_dst | bus.id_mem_write | bus.id_branch;

    assign hazard_p0 = ex_p1.valid & ex_p1.mem_read & (ex_p1.rt != 5'd0) & bus.id_valid &
                       ((ex_p1.rt == bus.id_rs) | ((ex_p1.rt == bus.id_rt) & rt_read_p0));

    assign bus.stall      = hazard_p0 & ~bus.ex_flush;
    assign load_bubble_p0 = bus.ex_flush | hazard_p0 | ~bus.id_valid;

    // ---- stage p1: execute-side register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_p1 <= '0;
        end else if (load_bubble_p0) begin
            ex_p1 <= '0;
        end else begin
            ex_p1 <= id_p0;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    // only hazard bubbles are counted; flush and empty-slot loads are not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= 32'd0;
        end else if (bus.stall) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

    assign bus.ex_valid      = ex_p1.valid;
    assign bus.ex_reg_write  = ex_p1.reg_write;
    assign bus.ex_is_signed  = ex_p1.is_signed;
    assign bus.ex_reg_dst    = ex_p1.reg_dst;
    assign bus.ex_jump       = ex_p1.jump;
    assign bus.ex_branch     = ex_p1.branch;
    assign bus.ex_mem_to_reg = ex_p1.mem_to_reg;
    assign bus.ex_mem_write  = ex_p1.mem_write;
    assign bus.ex_mem_read   = ex_p1.mem_read;
    assign bus.ex_alu_sel    = ex_p1.alu_sel;
    assign bus.ex_alu_code   = ex_p1.alu_code;
    assign bus.ex_rs         = ex_p1.rs;
    assign bus.ex_rt         = ex_p1.rt;
    assign bus.ex_rd         = ex_p1.rd;
    assign bus.ex_rs_data    = ex_p1.rs_data;
    assign bus.ex_rt_data    = ex_p1.rt_data;
    assign bus.ex_imm        = ex_p1.imm;
    assign bus.ex_pc4        = ex_p1.pc4;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed and randomized bench for id_ex_reg against an instruction-level
// reference model; bubble_cnt checks are included when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_reg;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              is_signed;
        logic              reg_dst;
        logic              jump;
        logic              branch;
        logic              mem_to_reg;
        logic              mem_write;
        logic              mem_read;
        logic [1:0]        alu_sel;
        logic [5:0]        alu_code;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
    } instr_t;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    instr_t model_ex;
    instr_t cur_id;
    logic   cur_flush;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    id_ex_reg_if #(.DATA_W(DATA_W)) bus ();

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
    id_ex_reg #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus), .bubble_cnt(bubble_cnt));
`else
    id_ex_reg #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    task automatic chk(input string tag, input logic [$bits(instr_t)-1:0] obs,
                       input logic [$bits(instr_t)-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t observe();
        instr_t s;
        s = '{valid: bus.ex_valid, reg_write: bus.ex_reg_write, is_signed: bus.ex_is_signed,
              reg_dst: bus.ex_reg_dst, jump: bus.ex_jump, branch: bus.ex_branch,
              mem_to_reg: bus.ex_mem_to_reg, mem_write: bus.ex_mem_write,
              mem_read: bus.ex_mem_read, alu_sel: bus.ex_alu_sel, alu_code: bus.ex_alu_code,
              rs: bus.ex_rs, rt: bus.ex_rt, rd: bus.ex_rd, rs_data: bus.ex_rs_data,
              rt_data: bus.ex_rt_data, imm: bus.ex_imm, pc4: bus.ex_pc4};
        return s;
    endfunction

    task automatic drive(input instr_t s, input logic flush);
        cur_id            = s;
        cur_flush         = flush;
        bus.id_valid      = s.valid;
        bus.id_reg_write  = s.reg_write;
        bus.id_is_signed  = s.is_signed;
        bus.id_reg_dst    = s.reg_dst;
        bus.id_jump       = s.jump;
        bus.id_branch     = s.branch;
        bus.id_mem_to_reg = s.mem_to_reg;
        bus.id_mem_write  = s.mem_write;
        bus.id_mem_read   = s.mem_read;
        bus.id_alu_sel    = s.alu_sel;
        bus.id_alu_code   = s.alu_code;
        bus.id_rs         = s.rs;
        bus.id_rt         = s.rt;
        bus.id_rd         = s.rd;
        bus.id_rs_data    = s.rs_data;
        bus.id_rt_data    = s.rt_data;
        bus.id_imm        = s.imm;
        bus.id_pc4        = s.pc4;
        bus.ex_flush      = flush;
    endtask

    // A load in EX blocks any ID instruction that reads its destination register.
    function automatic logic load_use(instr_t ex, instr_t id);
        logic reads_rt;
        reads_rt = id.reg_dst || id.mem_write || id.branch;
        if (!ex.valid || !ex.mem_read || ex.rt == 5'd0 || !id.valid) return 1'b0;
        return (ex.rt == id.rs) || (reads_rt && ex.rt == id.rt);
    endfunction

    // Check stall, advance one clock, advance the model, check the EX stage.
    task automatic step(input string tag);
        logic haz;
        #1;
        haz = load_use(model_ex, cur_id);
        chk({tag, "_stall"}, bus.stall, haz && !cur_flush);
        @(posedge clk);
        if (haz && !cur_flush) exp_cnt = exp_cnt + 32'd1;
        model_ex = (cur_flush || haz || !cur_id.valid) ? instr_t'('0) : cur_id;
        #1;
        chk({tag, "_ex"}, observe(), model_ex);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({tag, "_cnt"}, bubble_cnt, exp_cnt);
`endif
    endtask

    function automatic instr_t mk_lw(input logic [4:0] rt);
        instr_t s = '0;
        s.valid = 1'b1; s.reg_write = 1'b1; s.is_signed = 1'b1; s.mem_to_reg = 1'b1;
        s.mem_read = 1'b1; s.alu_sel = 2'b01; s.alu_code = 6'h20; s.rs = 5'd1; s.rt = rt;
        s.rs_data = 32'h0000_1000; s.imm = 32'h0000_0004; s.pc4 = 32'h0000_0100;
        return s;
    endfunction

    function automatic instr_t mk_add(input logic [4:0] rs, input logic [4:0] rt);
        instr_t s = '0;
        s.valid = 1'b1; s.reg_write = 1'b1; s.is_signed = 1'b1; s.reg_dst = 1'b1;
        s.alu_code = 6'h20; s.rs = rs; s.rt = rt; s.rd = 5'd7;
        s.rs_data = $urandom; s.rt_data = $urandom; s.pc4 = 32'h0000_0104;
        return s;
    endfunction

    function automatic instr_t mk_rand();
        instr_t s;
        s = '{valid: ($urandom_range(0, 9) < 8), reg_write: $urandom_range(0, 1),
              is_signed: $urandom_range(0, 1), reg_dst: $urandom_range(0, 1),
              jump: $urandom_range(0, 1), branch: $urandom_range(0, 1),
              mem_to_reg: $urandom_range(0, 1), mem_write: $urandom_range(0, 1),
              mem_read: ($urandom_range(0, 9) < 4), alu_sel: $urandom_range(0, 3),
              alu_code: $urandom_range(0, 63), rs: $urandom_range(0, 7),
              rt: $urandom_range(0, 7), rd: $urandom_range(0, 31), rs_data: $urandom,
              rt_data: $urandom, imm: $urandom, pc4: $urandom};
        return s;
    endfunction

    initial begin
        instr_t s;
        rst = 1'b1;
        exp_cnt = 32'd0;
        model_ex = '0;
        drive(mk_add(5'd2, 5'd3), 1'b0);

        // reset state, first capture right after release
        #2;
        chk("reset_ex", observe(), '0);
        chk("reset_stall", bus.stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step("first_capture");

        // load-use on rs: one bubble, then the add enters EX
        drive(mk_lw(5'd5), 1'b0);
        step("lu_lw");
        drive(mk_add(5'd5, 5'd6), 1'b0);
        #1;
        chk("lu_stall_on", bus.stall, 1'b1);
        step("lu_bubble");
        chk("lu_bubble_valid", bus.ex_valid, 1'b0);
        chk("lu_bubble_mem_read", bus.ex_mem_read, 1'b0);
        #1;
        chk("lu_stall_off", bus.stall, 1'b0);
        step("lu_add");
        chk("lu_add_valid", bus.ex_valid, 1'b1);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("lu_cnt_one", bubble_cnt, 32'd1);
`endif

        // $zero destination never stalls
        drive(mk_lw(5'd0), 1'b0);
        step("r0_lw");
        drive(mk_add(5'd0, 5'd0), 1'b0);
        step("r0_add");
        chk("r0_add_valid", bus.ex_valid, 1'b1);

        // addi reads only rs, so rt match is harmless
        drive(mk_lw(5'd5), 1'b0);
        step("addi_lw");
        s = '0;
        s.valid = 1'b1; s.reg_write = 1'b1; s.alu_sel = 2'b01; s.alu_code = 6'h08;
        s.rs = 5'd3; s.rt = 5'd5; s.imm = 32'hFFFF_FFF0; s.pc4 = 32'h0000_0108;
        drive(s, 1'b0);
        step("addi");
        chk("addi_rt", bus.ex_rt, 5'd5);

        // hazard coinciding with flush: bubble, no stall, not counted
        drive(mk_lw(5'd5), 1'b0);
        step("fl_lw");
        drive(mk_add(5'd5, 5'd6), 1'b1);
        step("fl_bubble");
        chk("fl_all_zero", observe(), '0);
        drive(mk_add(5'd2, 5'd3), 1'b0);

        // asynchronous reset between edges
        s = mk_add(5'd2, 5'd3);
        s.pc4 = 32'h0000_0040;
        drive(s, 1'b0);
        step("ar_capture");
        chk("ar_pre_reg_write", bus.ex_reg_write, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_reg_write", bus.ex_reg_write, 1'b0);
        chk("ar_pc4", bus.ex_pc4, 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("ar_cnt", bubble_cnt, 32'd0);
`endif
        model_ex = '0;
        exp_cnt  = 32'd0;
        #1;
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(mk_rand(), ($urandom_range(0, 9) == 0));
            step("rand");
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        // counter wrap
        drive(mk_lw(5'd5), 1'b0);
        step("wr_lw");
        force dut.bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        drive(mk_add(5'd5, 5'd6), 1'b0);
        step("wr_hazard");
        chk("wr_cnt_zero", bubble_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
